// File: rtl/eth_mac_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | eth_mac_tx_arbiter                                                         |
// | Frame-granular round-robin arbiter feeding the MAC TX FIFO; truncates and |
// | marks oversize frames bad, then drains their remainder from the requester.|
// | Optional: `define ETH_TX_ARB_PRIORITY_EN adds the s_priority request class.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module eth_mac_tx_arbiter #(
    parameter  int S_COUNT       = 4,
    parameter  int MAX_FRAME_LEN = 1518,
    localparam int IDX_WIDTH     = $clog2(S_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [S_COUNT*8-1:0]   s_axis_tdata,
    input  logic [S_COUNT-1:0]     s_axis_tvalid,
    output logic [S_COUNT-1:0]     s_axis_tready,
    input  logic [S_COUNT-1:0]     s_axis_tlast,
    input  logic [S_COUNT-1:0]     s_axis_tuser,
`ifdef ETH_TX_ARB_PRIORITY_EN
    input  logic [S_COUNT-1:0]     s_priority,
`endif
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    input  logic                   cfg_enable,
    output logic                   grant_valid,
    output logic [IDX_WIDTH-1:0]   grant_index,
    output logic                   status_oversize
);

    localparam int LEN_WIDTH = $clog2(MAX_FRAME_LEN + 1);

    localparam logic [LEN_WIDTH-1:0] c_last_beat = LEN_WIDTH'(MAX_FRAME_LEN - 1);
    localparam logic [IDX_WIDTH-1:0] c_ptr_init  = IDX_WIDTH'(S_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_grant_valid;
    logic [IDX_WIDTH-1:0]   r_grant_index;
    logic [IDX_WIDTH-1:0]   r_ptr;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic                   r_oversize;

    logic [S_COUNT-1:0]     w_req;
    logic                   w_pick_found;
    logic [IDX_WIDTH-1:0]   w_pick_idx;
    logic [7:0]             w_g_data;
    logic                   w_g_valid;
    logic                   w_g_last;
    logic                   w_g_user;
    logic                   w_trunc;
    logic                   w_accept;

    assign grant_valid     = r_grant_valid;
    assign grant_index     = r_grant_index;
    assign status_oversize = r_oversize;

    // Round-robin search: ports above the pointer first, then wrap to port 0.
    always_comb begin
        w_req = s_axis_tvalid;
`ifdef ETH_TX_ARB_PRIORITY_EN
        if (|(s_axis_tvalid & s_priority)) begin
            w_req = s_axis_tvalid & s_priority;
        end
`endif
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int j = 0; j < S_COUNT; j++) begin
            if (!w_pick_found && w_req[j] && (IDX_WIDTH'(j) > r_ptr)) begin
                w_pick_found = 1'b1;
                w_pick_idx   = IDX_WIDTH'(j);
            end
        end
        for (int j = 0; j < S_COUNT; j++) begin
            if (!w_pick_found && w_req[j]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = IDX_WIDTH'(j);
            end
        end
    end

    always_comb begin
        w_g_data  = s_axis_tdata[{r_grant_index, 3'b000} +: 8];
        w_g_valid = s_axis_tvalid[r_grant_index];
        w_g_last  = s_axis_tlast[r_grant_index];
        w_g_user  = s_axis_tuser[r_grant_index];
        w_trunc   = (r_cnt == c_last_beat) && !w_g_last;

        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        case (r_state)
            ST_XFER: begin
                m_axis_tdata                 = w_g_data;
                m_axis_tvalid                = w_g_valid;
                m_axis_tlast                 = w_g_last | w_trunc;
                m_axis_tuser                 = w_g_user | w_trunc;
                s_axis_tready[r_grant_index] = m_axis_tready;
            end
            ST_DRAIN: begin
                s_axis_tready[r_grant_index] = 1'b1;
            end
            default: ;
        endcase
        w_accept = m_axis_tvalid && m_axis_tready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_grant_valid <= 1'b0;
            r_grant_index <= '0;
            r_ptr         <= c_ptr_init;
            r_cnt         <= '0;
            r_oversize    <= 1'b0;
        end else begin
            r_oversize <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_enable && w_pick_found) begin
                        r_grant_index <= w_pick_idx;
                        r_grant_valid <= 1'b1;
                        r_state       <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_accept) begin
                        if (w_g_last) begin
                            r_cnt         <= '0;
                            r_ptr         <= r_grant_index;
                            r_grant_valid <= 1'b0;
                            r_state       <= ST_IDLE;
                        end else if (w_trunc) begin
                            r_cnt      <= '0;
                            r_oversize <= 1'b1;
                            r_state    <= ST_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + LEN_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Grant stays visible while the oversize remainder is discarded.
                    if (w_g_valid && w_g_last) begin
                        r_ptr         <= r_grant_index;
                        r_grant_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
